// File: rtl/os2byte_streamer.sv
// Serialises one captured big-endian octet string into a byte stream, MSB octet first,
// with an optional 2-byte big-endian length header; outputs are registered, valid/ready downstream.
module os2byte_streamer #(
    parameter int DATA_BIT_WIDTH = 2048,
    parameter int LEN_HEADER     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_BIT_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      overflow,
    output logic                      busy
);

    localparam int NB = DATA_BIT_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);
    localparam logic [15:0]   NB16     = 16'(NB);

    typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DATA_BIT_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_BIT_WIDTH-1:0] shreg_shift;
    logic [7:0]                out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_first_q, out_first_d;
    logic                      out_last_q, out_last_d;
    logic                      overflow_q, overflow_d;
    logic                      hs;

    assign hs          = out_valid_q & out_ready;
    assign shreg_shift = shreg_q << 8;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;

        // A pulse in any non-IDLE state, including the last-byte edge, is dropped.
        if (in_valid && (state_q != IDLE)) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d     = in_data;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    if (LEN_HEADER != 0) begin
                        state_d    = HDR_HI;
                        out_data_d = NB16[15:8];
                        out_last_d = 1'b0;
                    end else begin
                        state_d    = DATA;
                        out_data_d = in_data[DATA_BIT_WIDTH-1 -: 8];
                        out_last_d = (LAST_CNT == '0);
                    end
                end
            end
            HDR_HI: begin
                if (hs) begin
                    state_d     = HDR_LO;
                    out_data_d  = NB16[7:0];
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            HDR_LO: begin
                if (hs) begin
                    state_d     = DATA;
                    out_data_d  = shreg_q[DATA_BIT_WIDTH-1 -: 8];
                    out_first_d = 1'b0;
                    out_last_d  = (LAST_CNT == '0);
                end
            end
            DATA: begin
                if (hs) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        shreg_d     = shreg_shift;
                        cnt_d       = cnt_q + CW'(1);
                        out_data_d  = shreg_shift[DATA_BIT_WIDTH-1 -: 8];
                        out_first_d = 1'b0;
                        out_last_d  = ((cnt_q + CW'(1)) == LAST_CNT);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_os2byte_streamer.sv
// Scoreboard bench: stimulus pushes expected beats, per-instance monitors pop and compare on each transfer.
module tb_os2byte_streamer;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 32-bit with header, B: 32-bit no header, C: 2048-bit with header
    logic        iv_a = 1'b0, rdy_a = 1'b1;
    logic [31:0] id_a = '0;
    logic        ir_a, ov_a, of_a, ol_a, ovf_a, bsy_a;
    logic [7:0]  od_a;

    logic        iv_b = 1'b0, rdy_b = 1'b1;
    logic [31:0] id_b = '0;
    logic        ir_b, ov_b, of_b, ol_b, ovf_b, bsy_b;
    logic [7:0]  od_b;

    logic          iv_c = 1'b0, rdy_c = 1'b1;
    logic [2047:0] id_c = '0;
    logic          ir_c, ov_c, of_c, ol_c, ovf_c, bsy_c;
    logic [7:0]    od_c;

    os2byte_streamer #(.DATA_BIT_WIDTH(32), .LEN_HEADER(1)) u_a (
        .clk(clk), .reset(rst_n), .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .out_first(of_a),
        .out_last(ol_a), .overflow(ovf_a), .busy(bsy_a));

    os2byte_streamer #(.DATA_BIT_WIDTH(32), .LEN_HEADER(0)) u_b (
        .clk(clk), .reset(rst_n), .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .out_first(of_b),
        .out_last(ol_b), .overflow(ovf_b), .busy(bsy_b));

    os2byte_streamer #(.DATA_BIT_WIDTH(2048), .LEN_HEADER(1)) u_c (
        .clk(clk), .reset(rst_n), .in_valid(iv_c), .in_data(id_c), .in_ready(ir_c),
        .out_data(od_c), .out_valid(ov_c), .out_ready(rdy_c), .out_first(of_c),
        .out_last(ol_c), .overflow(ovf_c), .busy(bsy_c));

    beat_t exp_a[$], exp_b[$], exp_c[$];
    int    xfer_a = 0, xfer_b = 0, xfer_c = 0;
    int    first_cyc_a = 0, last_cyc_a = 0, cap_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got unexpected/expired event expected none", nm);
    endtask

    // Monitors
    beat_t e_a, e_b, e_c;
    logic  hold_a = 1'b0;
    logic [9:0] prev_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) chk("a_hold", {od_a, of_a, ol_a}, prev_a);
            if (ov_a && rdy_a) begin
                if (exp_a.size() == 0) fail("a_extra_byte");
                else begin
                    e_a = exp_a.pop_front();
                    chk("a_byte", {od_a, of_a, ol_a}, e_a);
                    xfer_a++;
                    if (e_a.f) first_cyc_a = cyc;
                    if (e_a.l) last_cyc_a = cyc;
                end
            end
            hold_a = ov_a && !rdy_a;
            prev_a = {od_a, of_a, ol_a};
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov_b && rdy_b) begin
            if (exp_b.size() == 0) fail("b_extra_byte");
            else begin
                e_b = exp_b.pop_front();
                chk("b_byte", {od_b, of_b, ol_b}, e_b);
                xfer_b++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov_c && rdy_c) begin
            if (exp_c.size() == 0) fail("c_extra_byte");
            else begin
                e_c = exp_c.pop_front();
                chk("c_byte", {od_c, of_c, ol_c}, e_c);
                xfer_c++;
            end
        end
    end

    task automatic push_a(input logic [31:0] w);
        exp_a.push_back('{d: 8'h00, f: 1'b1, l: 1'b0});
        exp_a.push_back('{d: 8'h04, f: 1'b0, l: 1'b0});
        for (int i = 3; i >= 0; i--)
            exp_a.push_back('{d: w[8*i +: 8], f: 1'b0, l: (i == 0)});
    endtask

    task automatic push_b(input logic [31:0] w);
        for (int i = 3; i >= 0; i--)
            exp_b.push_back('{d: w[8*i +: 8], f: (i == 3), l: (i == 0)});
    endtask

    task automatic pulse_a(input logic [31:0] w);
        @(posedge clk); #1;
        iv_a = 1'b1; id_a = w;
        @(posedge clk); #1;
        iv_a = 1'b0;
        cap_cyc = cyc;
    endtask

    task automatic wait_empty(input int which, input int lim, input string nm);
        int n;
        n = (which == 0) ? exp_a.size() : (which == 1) ? exp_b.size() : exp_c.size();
        for (int i = 0; i < lim && n != 0; i++) begin
            @(posedge clk);
            n = (which == 0) ? exp_a.size() : (which == 1) ? exp_b.size() : exp_c.size();
        end
        if (n != 0) fail(nm);
        #1;
    endtask

    initial begin
        int base;
        // Reset state
        #12;
        chk("rst_in_ready", ir_a, 1);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_first_last", {of_a, ol_a}, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_busy", bsy_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: header + DEADBEEF at full rate
        push_a(32'hDEADBEEF);
        pulse_a(32'hDEADBEEF);
        chk("t1_busy_in_ready", {bsy_a, ir_a}, 2'b10);
        wait_empty(0, 40, "t1_timeout");
        chk("t1_in_ready_after", ir_a, 1);
        chk("t1_first_latency", first_cyc_a - cap_cyc, 0);
        chk("t1_consecutive", last_cyc_a - first_cyc_a, 5);

        // 2: no header, leading zeros kept
        push_b(32'h000000A5);
        @(posedge clk); #1 iv_b = 1'b1; id_b = 32'h000000A5;
        @(posedge clk); #1 iv_b = 1'b0;
        wait_empty(1, 40, "t2_timeout");
        chk("t2_count", xfer_b, 4);
        chk("t2_in_ready_after", ir_b, 1);

        // 3: backpressure 1,0,0 repeating
        base = xfer_a;
        push_a(32'hDEADBEEF);
        pulse_a(32'hDEADBEEF);
        for (int i = 0; i < 60 && exp_a.size() != 0; i++) begin
            @(posedge clk); #1;
            rdy_a = (i % 3 == 2);
        end
        if (exp_a.size() != 0) fail("t3_timeout");
        chk("t3_count", xfer_a - base, 6);
        rdy_a = 1'b1;
        @(posedge clk); #1;
        chk("t3_in_ready_after", ir_a, 1);

        // 4: overflow mid-frame
        push_a(32'hDEADBEEF);
        pulse_a(32'hDEADBEEF);
        @(posedge clk);
        pulse_a(32'h11223344);
        wait_empty(0, 40, "t4_timeout");
        chk("t4_overflow_set", ovf_a, 1);
        push_a(32'h55667788);
        pulse_a(32'h55667788);
        wait_empty(0, 40, "t4b_timeout");
        chk("t4_overflow_sticky", ovf_a, 1);

        // 5: async reset after the 3rd byte
        base = xfer_a;
        push_a(32'hABCD1234);
        pulse_a(32'hABCD1234);
        for (int i = 0; i < 50 && (xfer_a - base) < 3; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", ov_a, 0);
        chk("t5_in_ready", ir_a, 1);
        chk("t5_overflow", ovf_a, 0);
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_a(32'hCAFEF00D);
        pulse_a(32'hCAFEF00D);
        wait_empty(0, 40, "t5_timeout");
        chk("t5_overflow_after", ovf_a, 0);

        // 6: 2048-bit random
        for (int i = 0; i < 64; i++) id_c[32*i +: 32] = $urandom;
        exp_c.push_back('{d: 8'h01, f: 1'b1, l: 1'b0});
        exp_c.push_back('{d: 8'h00, f: 1'b0, l: 1'b0});
        for (int i = 0; i < 256; i++)
            exp_c.push_back('{d: id_c[2047-8*i -: 8], f: 1'b0, l: (i == 255)});
        @(posedge clk); #1 iv_c = 1'b1;
        @(posedge clk); #1 iv_c = 1'b0;
        wait_empty(2, 400, "t6_timeout");
        chk("t6_count", xfer_c, 258);
        chk("t6_in_ready_after", ir_c, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
